// File: rtl/load_balancer.sv
// load_balancer
//   Buffers request metadata in a FIFO and sends each request to a
//   reconfigurable region. The choice is made from the per-region
//   (operator ID, load) statistics. The least loaded region whose operator ID
//   matches the request wins. If no region matches, the least loaded region
//   overall wins. Ties go to the lowest region index.
//
// Configuration macro:
//   LB_STATS_REG_EN  when defined, region_stats_in is registered once and the
//                    registered copy is used for selection. Otherwise the
//                    input is used directly in the pop cycle.
//
// Ports:
//   aclk                  clock, rising edge
//   aresetn               synchronous reset, active high
//   meta_in_*             AXI4S sink for request metadata
//   hdr_in_*, bdy_in_*    AXI4S sinks, always ready, data discarded
//   region_stats_in       region i at [i*SW +: SW] = {operator ID, load}
//   meta_out_*            AXI4S source for dispatched metadata
//   lb_ctrl               target region index, qualified by meta_out_tvalid
module load_balancer #(
    parameter int HTTP_META_WIDTH   = 8,
    parameter int OPERATOR_ID_WIDTH = 4,
    parameter int N_REGIONS         = 4,
    parameter int QDEPTH            = 16,
    parameter int AXIS_DATA_WIDTH   = 512,
    localparam int PNTR_BITS        = $clog2(QDEPTH),
    localparam int SW               = OPERATOR_ID_WIDTH + PNTR_BITS,
    localparam int RW               = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       meta_in_tvalid,
    output logic                       meta_in_tready,
    input  logic [HTTP_META_WIDTH-1:0] meta_in_tdata,
    input  logic                       hdr_in_tvalid,
    output logic                       hdr_in_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] hdr_in_tdata,
    input  logic                       bdy_in_tvalid,
    output logic                       bdy_in_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] bdy_in_tdata,
    input  logic [N_REGIONS*SW-1:0]    region_stats_in,
    output logic                       meta_out_tvalid,
    input  logic                       meta_out_tready,
    output logic [HTTP_META_WIDTH-1:0] meta_out_tdata,
    output logic [RW-1:0]              lb_ctrl
);

    localparam int CNT_W = PNTR_BITS + 1;

    logic [HTTP_META_WIDTH-1:0] mem_q [QDEPTH];
    logic [PNTR_BITS-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PNTR_BITS-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       in_rdy_q, in_rdy_d;
    logic                       out_valid_q, out_valid_d;
    logic [HTTP_META_WIDTH-1:0] out_data_q, out_data_d;
    logic [RW-1:0]              out_ctrl_q, out_ctrl_d;

    logic                         push, pop, empty;
    logic [HTTP_META_WIDTH-1:0]   head;
    logic [OPERATOR_ID_WIDTH-1:0] req_id;
    logic [N_REGIONS*SW-1:0]      stats_sel;
    logic [RW-1:0]                sel_idx;

    // hdr/bdy streams are accepted and dropped.
    assign hdr_in_tready = 1'b1;
    assign bdy_in_tready = 1'b1;
    logic unused_streams;
    assign unused_streams = ^{hdr_in_tvalid, hdr_in_tdata, bdy_in_tvalid, bdy_in_tdata};

    // Ready is a registered "not full" flag. It is 0 while reset is asserted
    // and 1 from the first edge after release.
    assign meta_in_tready  = in_rdy_q;
    assign meta_out_tvalid = out_valid_q;
    assign meta_out_tdata  = out_data_q;
    assign lb_ctrl         = out_ctrl_q;

    assign empty  = (count_q == '0);
    assign push   = meta_in_tvalid && in_rdy_q;
    assign pop    = !empty && (!out_valid_q || meta_out_tready);
    assign head   = mem_q[rd_ptr_q];
    assign req_id = head[OPERATOR_ID_WIDTH-1:0];

`ifdef LB_STATS_REG_EN
    logic [N_REGIONS*SW-1:0] stats_q;
    always_ff @(posedge aclk) begin
        if (aresetn) stats_q <= '0;
        else         stats_q <= region_stats_in;
    end
    assign stats_sel = stats_q;
`else
    assign stats_sel = region_stats_in;
`endif

    // Region selection. Strict less-than keeps the earliest index on ties.
    logic                         match_found;
    logic [RW-1:0]                match_idx, min_idx;
    logic [PNTR_BITS-1:0]         match_load, min_load, ld_i;
    logic [OPERATOR_ID_WIDTH-1:0] id_i;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        match_load  = '0;
        min_idx     = '0;
        min_load    = stats_sel[PNTR_BITS-1:0];
        ld_i        = '0;
        id_i        = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            ld_i = stats_sel[i*SW +: PNTR_BITS];
            id_i = stats_sel[i*SW+PNTR_BITS +: OPERATOR_ID_WIDTH];
            if (ld_i < min_load) begin
                min_load = ld_i;
                min_idx  = RW'(i);
            end
            if (id_i == req_id && (!match_found || ld_i < match_load)) begin
                match_found = 1'b1;
                match_load  = ld_i;
                match_idx   = RW'(i);
            end
        end
        sel_idx = match_found ? match_idx : min_idx;
    end

    function automatic logic [PNTR_BITS-1:0] ptr_inc(input logic [PNTR_BITS-1:0] p);
        return (p == PNTR_BITS'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        in_rdy_d = (count_d != CNT_W'(QDEPTH));

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head;
            out_ctrl_d  = sel_idx;
        end else if (meta_out_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_rdy_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_rdy_q    <= in_rdy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
        end
    end

    // Storage needs no reset: entries are only read when count_q says so.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= meta_in_tdata;
    end

endmodule

// File: tb/tb_load_balancer.sv
module tb_load_balancer;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         meta_in_tvalid;
    logic         meta_in_tready;
    logic [7:0]   meta_in_tdata;
    logic         hdr_in_tready, bdy_in_tready;
    logic [31:0]  region_stats_in;
    logic         meta_out_tvalid;
    logic         meta_out_tready;
    logic [7:0]   meta_out_tdata;
    logic [1:0]   lb_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    load_balancer dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .meta_in_tvalid  (meta_in_tvalid),
        .meta_in_tready  (meta_in_tready),
        .meta_in_tdata   (meta_in_tdata),
        .hdr_in_tvalid   (1'b0),
        .hdr_in_tready   (hdr_in_tready),
        .hdr_in_tdata    ('0),
        .bdy_in_tvalid   (1'b0),
        .bdy_in_tready   (bdy_in_tready),
        .bdy_in_tdata    ('0),
        .region_stats_in (region_stats_in),
        .meta_out_tvalid (meta_out_tvalid),
        .meta_out_tready (meta_out_tready),
        .meta_out_tdata  (meta_out_tdata),
        .lb_ctrl         (lb_ctrl)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        meta_in_tvalid = 1'b1;
        meta_in_tdata  = d;
        step();
        meta_in_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        repeat (3) step();
        checks++; if (meta_out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0b exp 0", meta_out_tvalid); end
        checks++; if (meta_out_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %h exp 00", meta_out_tdata); end
        checks++; if (lb_ctrl !== 2'd0) begin errors++; $display("FAIL rst_lb_ctrl got %0d exp 0", lb_ctrl); end
        checks++; if (meta_in_tready !== 1'b0) begin errors++; $display("FAIL rst_in_tready got %0b exp 0", meta_in_tready); end
        checks++; if ({hdr_in_tready, bdy_in_tready} !== 2'b11) begin errors++; $display("FAIL hdr_bdy_tready got %b exp 11", {hdr_in_tready, bdy_in_tready}); end
        aresetn = 1'b0;
        step();
        checks++; if (meta_in_tready !== 1'b1) begin errors++; $display("FAIL rel_in_tready got %0b exp 1", meta_in_tready); end
    endtask

    task automatic test_match();
        region_stats_in = 32'h91_34_60_73;
        meta_out_tready = 1'b1;
        push(8'hF9);
        checks++; if (meta_out_tvalid !== 1'b0) begin errors++; $display("FAIL match_early_tvalid got %0b exp 0", meta_out_tvalid); end
        step();
        checks++; if (meta_out_tvalid !== 1'b1) begin errors++; $display("FAIL match_tvalid got %0b exp 1", meta_out_tvalid); end
        checks++; if (meta_out_tdata !== 8'hF9) begin errors++; $display("FAIL match_tdata got %h exp F9", meta_out_tdata); end
        checks++; if (lb_ctrl !== 2'd3) begin errors++; $display("FAIL match_lb_ctrl got %0d exp 3", lb_ctrl); end
        step();
        checks++; if (meta_out_tvalid !== 1'b0) begin errors++; $display("FAIL match_drop got %0b exp 0", meta_out_tvalid); end
    endtask

    task automatic test_nomatch();
        region_stats_in = 32'h91_34_60_73;
        push(8'hF5);
        step();
        checks++; if (meta_out_tvalid !== 1'b1 || meta_out_tdata !== 8'hF5) begin errors++; $display("FAIL nomatch_out got v=%0b d=%h exp v=1 d=F5", meta_out_tvalid, meta_out_tdata); end
        checks++; if (lb_ctrl !== 2'd1) begin errors++; $display("FAIL nomatch_lb_ctrl got %0d exp 1", lb_ctrl); end
        step();
    endtask

    task automatic test_tie();
        region_stats_in = 32'h92_92_00_00;
        push(8'h09);
        step();
        checks++; if (meta_out_tvalid !== 1'b1 || meta_out_tdata !== 8'h09) begin errors++; $display("FAIL tie_out got v=%0b d=%h exp v=1 d=09", meta_out_tvalid, meta_out_tdata); end
        checks++; if (lb_ctrl !== 2'd2) begin errors++; $display("FAIL tie_lb_ctrl got %0d exp 2", lb_ctrl); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        logic [1:0] exp_c [3];
        exp_d = '{8'hF5, 8'hF9, 8'hF5};
        exp_c = '{2'd1, 2'd3, 2'd1};
        region_stats_in = 32'h91_34_60_73;
        meta_out_tready = 1'b0;
        push(8'hF5);
        push(8'hF9);
        push(8'hF5);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (meta_out_tvalid !== 1'b1 || meta_out_tdata !== 8'hF5 || lb_ctrl !== 2'd1) begin
                errors++; $display("FAIL hold_%0d got v=%0b d=%h c=%0d exp v=1 d=F5 c=1", k, meta_out_tvalid, meta_out_tdata, lb_ctrl);
            end
            step();
        end
        meta_out_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (meta_out_tvalid !== 1'b1 || meta_out_tdata !== exp_d[k] || lb_ctrl !== exp_c[k]) begin
                errors++; $display("FAIL order_%0d got v=%0b d=%h c=%0d exp v=1 d=%h c=%0d", k, meta_out_tvalid, meta_out_tdata, lb_ctrl, exp_d[k], exp_c[k]);
            end
            step();
        end
        checks++; if (meta_out_tvalid !== 1'b0) begin errors++; $display("FAIL order_drain got %0b exp 0", meta_out_tvalid); end
    endtask

    task automatic test_full();
        int   accepted = 0;
        logic acc;
        meta_out_tready = 1'b0;
        meta_in_tvalid  = 1'b1;
        meta_in_tdata   = 8'd0;
        repeat (25) begin
            acc = meta_in_tready;
            step();
            if (acc) begin
                accepted++;
                meta_in_tdata = 8'(accepted);
            end
        end
        checks++; if (accepted != 17) begin errors++; $display("FAIL full_accepted got %0d exp 17", accepted); end
        checks++; if (meta_in_tready !== 1'b0) begin errors++; $display("FAIL full_tready got %0b exp 0", meta_in_tready); end
        checks++; if (meta_out_tdata !== 8'd0) begin errors++; $display("FAIL full_head got %h exp 00", meta_out_tdata); end
        meta_out_tready = 1'b1;
        step();
        meta_out_tready = 1'b0;
        meta_in_tvalid  = 1'b0;
        checks++; if (meta_in_tready !== 1'b1) begin errors++; $display("FAIL full_reopen got %0b exp 1", meta_in_tready); end
        meta_out_tready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (meta_out_tvalid !== 1'b1 || meta_out_tdata !== 8'(k)) begin
                errors++; $display("FAIL full_drain_%0d got v=%0b d=%h exp v=1 d=%h", k, meta_out_tvalid, meta_out_tdata, 8'(k));
            end
            step();
        end
        checks++; if (meta_out_tvalid !== 1'b0) begin errors++; $display("FAIL full_empty got %0b exp 0", meta_out_tvalid); end
    endtask

    task automatic test_reset_mid();
        region_stats_in = 32'h91_34_60_73;
        meta_out_tready = 1'b0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        checks++; if (meta_out_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pending got %0b exp 1", meta_out_tvalid); end
        aresetn = 1'b1;
        step();
        checks++; if (meta_out_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %0b exp 0", meta_out_tvalid); end
        checks++; if (meta_in_tready !== 1'b0) begin errors++; $display("FAIL mid_in_tready got %0b exp 0", meta_in_tready); end
        aresetn = 1'b0;
        meta_out_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (meta_out_tvalid !== 1'b0 || meta_out_tdata !== 8'h00) begin
                errors++; $display("FAIL mid_stale_%0d got v=%0b d=%h exp v=0 d=00", k, meta_out_tvalid, meta_out_tdata);
            end
        end
        push(8'h3C);
        step();
        checks++; if (meta_out_tvalid !== 1'b1 || meta_out_tdata !== 8'h3C) begin errors++; $display("FAIL mid_resume got v=%0b d=%h exp v=1 d=3C", meta_out_tvalid, meta_out_tdata); end
        step();
    endtask

    initial begin
        aresetn         = 1'b1;
        meta_in_tvalid  = 1'b0;
        meta_in_tdata   = 8'h00;
        meta_out_tready = 1'b0;
        region_stats_in = 32'h0;
        test_reset();
        test_match();
        test_nomatch();
        test_tie();
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
